simd_regfile: RTL and testbench

SIMD_REGFILE -- requirements
Module: simd_regfile

---
 rtl/simd_regfile_pkg.sv | 20 ++
 rtl/simd_regfile_byte_merge.sv | 27 ++
 rtl/simd_regfile_cells.sv | 44 ++++
 rtl/simd_regfile.sv | 145 ++++++++++++++
 tb/tb_simd_regfile.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_regfile_pkg.sv
// Shared regfile package: default geometry and the index-width helper.
// Imported by the register file top and its cells.
package simd_regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 8;

    // Index width for n entries (ceil(log2(n))).
    function automatic int idx_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/simd_regfile_byte_merge.sv
// Per-byte two-port merge: port 0 over port 1 over base data.
// Ports: en0_i/be0_i/d0_i, en1_i/be1_i/d1_i, base_i -> q_o.
module byte_merge #(
    parameter int NB = 8
) (
    input  logic            en0_i,
    input  logic [NB-1:0]   be0_i,
    input  logic [NB*8-1:0] d0_i,
    input  logic            en1_i,
    input  logic [NB-1:0]   be1_i,
    input  logic [NB*8-1:0] d1_i,
    input  logic [NB*8-1:0] base_i,
    output logic [NB*8-1:0] q_o
);

    always_comb begin
        q_o = base_i;
        for (int b = 0; b < NB; b++) begin
            priority case (1'b1)
                en0_i && be0_i[b]: q_o[b*8 +: 8] = d0_i[b*8 +: 8];
                en1_i && be1_i[b]: q_o[b*8 +: 8] = d1_i[b*8 +: 8];
                default:           q_o[b*8 +: 8] = base_i[b*8 +: 8];
            endcase
        end
    end

endmodule

// File: rtl/simd_regfile_cells.sv
// Codebase cells: one-hot index decoder and byte-enabled register.
// onehot_dec: en_i, idx_i -> oh_o.  regfile_cell: clk, rst_n, ld_i, d_i -> q_o.
module onehot_dec #(
    parameter int AW = 3
) (
    input  logic               en_i,
    input  logic [AW-1:0]      idx_i,
    output logic [(1<<AW)-1:0] oh_o
);

    always_comb begin
        oh_o        = '0;
        oh_o[idx_i] = en_i;
    end

endmodule

module regfile_cell #(
    parameter int NB = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NB-1:0]   ld_i,
    input  logic [NB*8-1:0] d_i,
    output logic [NB*8-1:0] q_o
);

    logic [NB*8-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (ld_i[b]) begin
                    data_q[b*8 +: 8] <= d_i[b*8 +: 8];
                end
            end
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/simd_regfile.sv
// Two-write / two-read SIMD register file with byte enables, write bypass
// and a per-register busy scoreboard (alloc sets, write-with-clear clears).
// Ports: clk, rst_n; write ports 0/1 (en, reg, be, data, clr);
// read ports 1/2 (reg -> data, busy); alloc_en/alloc_reg -> alloc_stall.
module simd_regfile
    import simd_regfile_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = idx_w(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en0,
    input  logic              wr_en1,
    input  logic [AW-1:0]     wr_reg0,
    input  logic [AW-1:0]     wr_reg1,
    input  logic [BE_W-1:0]   wr_be0,
    input  logic [BE_W-1:0]   wr_be1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              wr_clr0,
    input  logic              wr_clr1,
    input  logic [AW-1:0]     rd_reg1,
    input  logic [AW-1:0]     rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_reg,
    output logic              alloc_stall
);

    logic [DEPTH-1:0]  hit0;
    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  set;
    logic [DEPTH-1:0]  clr;
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              alloc_ok;
    logic [DATA_W-1:0] mem [DEPTH];

    onehot_dec #(.AW(AW)) u_dec0 (
        .en_i  (wr_en0),
        .idx_i (wr_reg0),
        .oh_o  (hit0)
    );

    onehot_dec #(.AW(AW)) u_dec1 (
        .en_i  (wr_en1),
        .idx_i (wr_reg1),
        .oh_o  (hit1)
    );

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        logic [DATA_W-1:0] wd;
        logic [BE_W-1:0]   ld;

        assign ld = ({BE_W{hit0[r]}} & wr_be0)
                  | ({BE_W{hit1[r]}} & wr_be1);

        byte_merge #(.NB(BE_W)) u_wmerge (
            .en0_i  (hit0[r]),
            .be0_i  (wr_be0),
            .d0_i   (wr_data0),
            .en1_i  (hit1[r]),
            .be1_i  (wr_be1),
            .d1_i   (wr_data1),
            .base_i (mem[r]),
            .q_o    (wd)
        );

        regfile_cell #(.NB(BE_W)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .ld_i  (ld),
            .d_i   (wd),
            .q_o   (mem[r])
        );
    end

    // Bypass uses the same merge cell as the write path so precedence matches.
    logic byp01;
    logic byp11;
    logic byp02;
    logic byp12;

    assign byp01 = wr_en0 && (wr_reg0 == rd_reg1);
    assign byp11 = wr_en1 && (wr_reg1 == rd_reg1);
    assign byp02 = wr_en0 && (wr_reg0 == rd_reg2);
    assign byp12 = wr_en1 && (wr_reg1 == rd_reg2);

    byte_merge #(.NB(BE_W)) u_byp1 (
        .en0_i  (byp01),
        .be0_i  (wr_be0),
        .d0_i   (wr_data0),
        .en1_i  (byp11),
        .be1_i  (wr_be1),
        .d1_i   (wr_data1),
        .base_i (mem[rd_reg1]),
        .q_o    (rd_data1)
    );

    byte_merge #(.NB(BE_W)) u_byp2 (
        .en0_i  (byp02),
        .be0_i  (wr_be0),
        .d0_i   (wr_data0),
        .en1_i  (byp12),
        .be1_i  (wr_be1),
        .d1_i   (wr_data1),
        .base_i (mem[rd_reg2]),
        .q_o    (rd_data2)
    );

    // Stall looks only at registered busy; a same-cycle clear does not help.
    assign alloc_stall = alloc_en & busy_q[alloc_reg];
    assign alloc_ok    = alloc_en & ~alloc_stall;

    onehot_dec #(.AW(AW)) u_deca (
        .en_i  (alloc_ok),
        .idx_i (alloc_reg),
        .oh_o  (set)
    );

    // hit0/hit1 already carry wr_en, so a bare clear is ignored.
    assign clr = (hit0 & {DEPTH{wr_clr0}})
               | (hit1 & {DEPTH{wr_clr1}});

    // Set after clear: a same-cycle alloc and clear leaves the bit set.
    assign busy_d = (busy_q & ~clr) | set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_busy1 = busy_q[rd_reg1];
    assign rd_busy2 = busy_q[rd_reg2];

endmodule

// File: tb/tb_simd_regfile.sv
// Directed bench for simd_regfile: 64x8 and 128x16 instances,
// shared stimulus, hand-computed expectations.
module tb_simd_regfile;

    logic         clk;
    logic         rst_n;
    logic         wr_en0;
    logic         wr_en1;
    logic [3:0]   wr_reg0;
    logic [3:0]   wr_reg1;
    logic [15:0]  wr_be0;
    logic [15:0]  wr_be1;
    logic [127:0] wr_data0;
    logic [127:0] wr_data1;
    logic         wr_clr0;
    logic         wr_clr1;
    logic [3:0]   rd_reg1;
    logic [3:0]   rd_reg2;
    logic         alloc_en;
    logic [3:0]   alloc_reg;

    logic [63:0]  rd1_64;
    logic [63:0]  rd2_64;
    logic         b1_64;
    logic         b2_64;
    logic         st_64;
    logic [127:0] rd1_128;
    logic [127:0] rd2_128;
    logic         b1_128;
    logic         b2_128;
    logic         st_128;

    logic         w128;
    logic [127:0] o_rd1;
    logic [127:0] o_rd2;
    logic         o_b1;
    logic         o_b2;
    logic         o_st;

    int nerr;
    int nchk;

    simd_regfile #(.DATA_W(64), .DEPTH(8)) u_dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en0      (wr_en0),
        .wr_en1      (wr_en1),
        .wr_reg0     (wr_reg0[2:0]),
        .wr_reg1     (wr_reg1[2:0]),
        .wr_be0      (wr_be0[7:0]),
        .wr_be1      (wr_be1[7:0]),
        .wr_data0    (wr_data0[63:0]),
        .wr_data1    (wr_data1[63:0]),
        .wr_clr0     (wr_clr0),
        .wr_clr1     (wr_clr1),
        .rd_reg1     (rd_reg1[2:0]),
        .rd_reg2     (rd_reg2[2:0]),
        .rd_data1    (rd1_64),
        .rd_data2    (rd2_64),
        .rd_busy1    (b1_64),
        .rd_busy2    (b2_64),
        .alloc_en    (alloc_en),
        .alloc_reg   (alloc_reg[2:0]),
        .alloc_stall (st_64)
    );

    simd_regfile #(.DATA_W(128), .DEPTH(16)) u_dut128 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en0      (wr_en0),
        .wr_en1      (wr_en1),
        .wr_reg0     (wr_reg0),
        .wr_reg1     (wr_reg1),
        .wr_be0      (wr_be0),
        .wr_be1      (wr_be1),
        .wr_data0    (wr_data0),
        .wr_data1    (wr_data1),
        .wr_clr0     (wr_clr0),
        .wr_clr1     (wr_clr1),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .rd_data1    (rd1_128),
        .rd_data2    (rd2_128),
        .rd_busy1    (b1_128),
        .rd_busy2    (b2_128),
        .alloc_en    (alloc_en),
        .alloc_reg   (alloc_reg),
        .alloc_stall (st_128)
    );

    always_comb begin
        o_rd1 = w128 ? rd1_128 : {64'd0, rd1_64};
        o_rd2 = w128 ? rd2_128 : {64'd0, rd2_64};
        o_b1  = w128 ? b1_128 : b1_64;
        o_b2  = w128 ? b2_128 : b2_64;
        o_st  = w128 ? st_128 : st_64;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s w128=%0d got=%h exp=%h",
                     tag, w128, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en0    = 1'b0;
        wr_en1    = 1'b0;
        wr_reg0   = '0;
        wr_reg1   = '0;
        wr_be0    = '0;
        wr_be1    = '0;
        wr_data0  = '0;
        wr_data1  = '0;
        wr_clr0   = 1'b0;
        wr_clr1   = 1'b0;
        alloc_en  = 1'b0;
        alloc_reg = '0;
    endtask

    task automatic run_phase();
        logic [3:0]   hi;
        logic [15:0]  bef;
        logic [127:0] pat;
        logic [127:0] pat2;
        logic [127:0] exp5;
        logic [127:0] exp2;

        hi   = w128 ? 4'd15 : 4'd7;
        bef  = w128 ? 16'hFFFF : 16'h00FF;
        pat  = w128 ? {2{64'h1122334455667788}}
                    : {64'd0, 64'h1122334455667788};
        pat2 = w128 ? {2{64'h0123456789ABCDEF}}
                    : {64'd0, 64'h0123456789ABCDEF};
        exp5 = w128 ? 128'hAAAAAAAAAAAAAAAAAAAAAAAA00000000
                    : 128'h0000000000000000AAAAAAAA00000000;
        exp2 = w128 ? 128'h22222222222222222222222222221111
                    : 128'h00000000000000002222222222221111;

        // Reset: writes and allocs presented during reset must not stick.
        idle();
        rst_n = 1'b0;
        wr_en0   = 1'b1;
        wr_reg0  = 4'd1;
        wr_be0   = bef;
        wr_data0 = pat;
        alloc_en  = 1'b1;
        alloc_reg = 4'd1;
        rd_reg1 = 4'd1;
        rd_reg2 = hi;
        #1;
        chk("rst_byp", o_rd1, pat);
        chk("rst_rdhi", o_rd2, 128'd0);
        chk("rst_stall", {127'd0, o_st}, 128'd0);
        chk("rst_busy", {127'd0, o_b1}, 128'd0);
        tick();
        idle();
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_nowr", o_rd1, 128'd0);
        chk("rst_noal", {127'd0, o_b1}, 128'd0);

        // Full write via port 0 to reg3, port 1 to top index.
        tick();
        wr_en0   = 1'b1;
        wr_reg0  = 4'd3;
        wr_be0   = bef;
        wr_data0 = pat;
        wr_en1   = 1'b1;
        wr_reg1  = hi;
        wr_be1   = bef;
        wr_data1 = pat2;
        tick();
        idle();
        rd_reg1 = 4'd3;
        rd_reg2 = 4'd0;
        #1;
        chk("r3", o_rd1, pat);
        chk("r0", o_rd2, 128'd0);
        rd_reg1 = hi;
        rd_reg2 = 4'd4;
        #1;
        chk("rhi", o_rd1, pat2);
        chk("r4", o_rd2, 128'd0);

        // Partial write with same-cycle bypass.
        wr_en0   = 1'b1;
        wr_reg0  = 4'd5;
        wr_be0   = bef;
        wr_data0 = {16{8'hAA}};
        tick();
        wr_en0   = 1'b1;
        wr_reg0  = 4'd5;
        wr_be0   = 16'h000F;
        wr_data0 = '0;
        rd_reg1  = 4'd5;
        #1;
        chk("byp5", o_rd1, exp5);
        tick();
        idle();
        #1;
        chk("st5", o_rd1, exp5);

        // Both ports on reg2: port 0 wins its two bytes.
        wr_en0   = 1'b1;
        wr_reg0  = 4'd2;
        wr_be0   = 16'h0003;
        wr_data0 = {16{8'h11}};
        wr_en1   = 1'b1;
        wr_reg1  = 4'd2;
        wr_be1   = bef;
        wr_data1 = {16{8'h22}};
        rd_reg2  = 4'd2;
        #1;
        chk("byp2", o_rd2, exp2);
        tick();
        idle();
        #1;
        chk("st2", o_rd2, exp2);

        // Scoreboard on reg6.
        alloc_en  = 1'b1;
        alloc_reg = 4'd6;
        rd_reg1   = 4'd6;
        #1;
        chk("al_st0", {127'd0, o_st}, 128'd0);
        chk("al_nobyp", {127'd0, o_b1}, 128'd0);
        tick();
        #1;
        chk("al_stall", {127'd0, o_st}, 128'd1);
        chk("al_busy", {127'd0, o_b1}, 128'd1);
        tick();
        alloc_en = 1'b0;
        wr_clr0  = 1'b1;
        wr_reg0  = 4'd6;
        tick();
        #1;
        chk("clr_noen", {127'd0, o_b1}, 128'd1);
        wr_en0   = 1'b1;
        wr_be0   = '0;
        wr_data0 = {16{8'h55}};
        tick();
        idle();
        #1;
        chk("clr", {127'd0, o_b1}, 128'd0);
        chk("be0_hold", o_rd1, 128'd0);
        wr_en1    = 1'b1;
        wr_reg1   = 4'd6;
        wr_clr1   = 1'b1;
        alloc_en  = 1'b1;
        alloc_reg = 4'd6;
        #1;
        chk("alclr_st", {127'd0, o_st}, 128'd0);
        tick();
        idle();
        #1;
        chk("alclr", {127'd0, o_b1}, 128'd1);

        // Asynchronous reset between edges.
        rd_reg1 = 4'd3;
        rd_reg2 = 4'd6;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_d3", o_rd1, 128'd0);
        chk("arst_b6", {127'd0, o_b2}, 128'd0);
        rd_reg1 = hi;
        rd_reg2 = 4'd5;
        #1;
        chk("arst_dhi", o_rd1, 128'd0);
        chk("arst_d5", o_rd2, 128'd0);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        nerr  = 0;
        nchk  = 0;
        w128  = 1'b0;
        rst_n = 1'b0;
        rd_reg1 = '0;
        rd_reg2 = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            w128 = (p == 1);
            run_phase();
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
